// File: rtl/photon_pkt_framer_if.sv
// photon_pkt_framer_if: packet stream from the framer to the UDP tx stage.
// Header/body words with sop/eop framing and a valid/ready handshake.
interface photon_pkt_framer_if;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        out_ready;

  modport master (
    output out_data, out_valid, out_sop, out_eop,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sop, out_eop,
    output out_ready
  );
endinterface

// File: rtl/photon_pkt_framer.sv
// photon_pkt_framer: buffers photon words and frames them into packets.
// Optional timeout flush of partial packets: PHOTON_FRAMER_TIMEOUT_EN.
module photon_pkt_framer #(
  parameter int FIFO_DEPTH  = 256,
  parameter int MAX_PHOTONS = 100,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        user_clk,
  input  logic                        user_rst_n,
  input  logic [31:0]                 port_cfg,
  input  logic [63:0]                 photon_data,
  input  logic                        photon_valid,
  photon_pkt_framer_if.master         tx,
  output logic [31:0]                 drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY
  } state_t;

  if (MAX_PHOTONS > FIFO_DEPTH || MAX_PHOTONS < 1 ||
      TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("photon_pkt_framer: bad parameters");
  end

  state_t         state;
  logic [63:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [15:0]    seq;
  logic [15:0]    nphot;
  logic [15:0]    remaining;
  logic           enable;
  logic           full;
  logic           push;
  logic           pop;
  logic           drop;
  logic           accept;
  logic           start;
  logic           timeout;
  logic [CW-1:0]  take;
  logic           unused_cfg;

  assign enable     = port_cfg[31];
  assign unused_cfg = &{1'b0, port_cfg[30:16]};

  // Handshake, FIFO control and packet-start decisions.
  always_comb begin
    full   = fifo_count == CW'(FIFO_DEPTH);
    push   = photon_valid && enable && !full;
    drop   = photon_valid && enable && full;
    accept = tx.out_valid && tx.out_ready;
    pop    = (state == BODY && accept) ||
             (state == IDLE && !enable && fifo_count != '0);
    take   = (fifo_count >= CW'(MAX_PHOTONS)) ?
             CW'(MAX_PHOTONS) : fifo_count;
    start  = state == IDLE && enable &&
             (fifo_count >= CW'(MAX_PHOTONS) ||
              (timeout && fifo_count != '0));
  end

`ifdef PHOTON_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [TW-1:0] timer;

  assign timeout = timer == TW'(TIMEOUT_CYC - 1);

  // Age of the oldest waiting photon while idle and enabled.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      timer <= '0;
    end else if (state == IDLE && enable &&
                 fifo_count != '0 && !start) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Photon storage; no reset so it maps onto RAM.
  always_ff @(posedge user_clk) begin
    if (push) begin
      mem[wr_ptr] <= photon_data;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

  // Packet FSM with registered stream outputs.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state        <= IDLE;
      seq          <= '0;
      nphot        <= '0;
      remaining    <= '0;
      tx.out_valid <= 1'b0;
      tx.out_sop   <= 1'b0;
      tx.out_eop   <= 1'b0;
      tx.out_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= HDR;
            nphot        <= 16'(take);
            tx.out_valid <= 1'b1;
            tx.out_sop   <= 1'b1;
            tx.out_eop   <= 1'b0;
            tx.out_data  <= {16'hF0E1, port_cfg[15:0],
                             seq, 16'(take)};
          end
        end
        HDR: begin
          if (accept) begin
            state       <= BODY;
            seq         <= seq + 16'd1;
            remaining   <= nphot;
            tx.out_sop  <= 1'b0;
            tx.out_eop  <= nphot == 16'd1;
            tx.out_data <= mem[rd_ptr];
          end
        end
        BODY: begin
          if (accept) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state        <= IDLE;
              tx.out_valid <= 1'b0;
              tx.out_eop   <= 1'b0;
              tx.out_data  <= '0;
            end else begin
              tx.out_eop  <= remaining == 16'd2;
              tx.out_data <= mem[rd_ptr + AW'(1)];
            end
          end
        end
        default: begin
          state        <= IDLE;
          tx.out_valid <= 1'b0;
          tx.out_sop   <= 1'b0;
          tx.out_eop   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/photon_pkt_framer.md
Name: photon_pkt_framer

Overview:
- Sits directly downstream of the photon_port software register and consumes its 32-bit user_data_out as port_cfg.
- Buffers 64-bit photon event words from the photon capture pipeline in a FIFO and groups them into packets. Each packet is one header word followed by up to MAX_PHOTONS photon words.
- The header carries the destination port, a sequence number and the photon count. Packets go to the 10GbE/UDP transmit stage over a valid/ready stream.

Parameters:
- FIFO_DEPTH, 256, photon FIFO depth in words; power of 2, at least MAX_PHOTONS.
- MAX_PHOTONS, 100, maximum photon words per packet (1..FIFO_DEPTH).
- TIMEOUT_CYC, 4096, cycles a non-empty FIFO may wait before a partial packet is flushed (≥2).

Ports:
- user_clk  in  1  single clock for the whole block.
- user_rst_n  in  1  synchronous active-low reset, sampled on the user_clk rising edge.
- port_cfg  in  32  from the photon_port register. [15:0] = UDP destination port, [31] = enable, others ignored.
- photon_data  in  64  photon event word.
- photon_valid  in  1  photon_data is valid this cycle. No backpressure is applied to this input.
- out_data  out  64  packet stream data.
- out_valid  out  1  out_data is valid.
- out_sop  out  1  first word (header) of a packet.
- out_eop  out  1  last word of a packet.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.
- drop_cnt  out  32  photons dropped because the FIFO was full; saturates at 0xFFFFFFFF.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (user_rst_n=0 at an edge):
  - out_valid, out_sop, out_eop = 0; out_data = 0.
  - drop_cnt = 0, fifo_count = 0, seq = 0, timer = 0, state = IDLE.
  - Reset mid-packet abandons the packet immediately; no eop is emitted.
- FIFO:
  - Write when photon_valid && enable && fifo_count < FIFO_DEPTH.
  - The full test uses the registered count, so a write arriving while full is dropped even if a pop happens in the same cycle.
  - A dropped write while enable=1 increments drop_cnt (saturating).
  - Read data is first-word-fall-through from the head.
  - Simultaneous push and pop leaves the count unchanged; pointers wrap modulo FIFO_DEPTH.
- Disable (port_cfg[31]=0):
  - New photons are ignored and not counted as drops.
  - In IDLE, the FIFO drains silently at one pop per cycle.
  - A packet already in HDR/BODY completes normally.
- Timer:
  - In IDLE with fifo_count>0 and enable=1, the timer increments each cycle. Otherwise it is 0.
  - timeout = (timer == TIMEOUT_CYC-1).
- State machine IDLE / HDR / BODY:
  - IDLE→HDR when enable && (fifo_count ≥ MAX_PHOTONS || (timeout && fifo_count>0)).
    - On this transition, latch nphot = min(fifo_count, MAX_PHOTONS) and dport = port_cfg[15:0].
    - Clear the timer.
  - HDR:
    - out_valid=1, out_sop=1, out_eop=0.
    - out_data = {16'hF0E1, dport, seq, nphot}, MSB first.
    - On accept: seq <= seq+1 (16-bit wrap), remaining <= nphot, go to BODY.
  - BODY:
    - out_valid=1, out_data = FIFO head, out_eop = (remaining==1).
    - On accept: pop FIFO and decrement remaining. After the eop word is accepted, go to IDLE.
  - out_data, out_sop and out_eop are held stable while out_valid && !out_ready.
  - port_cfg changes mid-packet do not affect that packet.
- Latency:
  - The photon that brings the count to MAX_PHOTONS (photon_valid in cycle N) produces the header with out_valid=1 in cycle N+2.
  - The first body word appears in the cycle after the header is accepted.
- Back-to-back: IDLE lasts at least one cycle between packets.

Optional Feature:
- Macro PHOTON_FRAMER_TIMEOUT_EN.
- Defined: the timer and timeout flush operate as above.
- Undefined:
  - No timer logic is built and packets start only when fifo_count ≥ MAX_PHOTONS.
  - Photons below that threshold stay buffered indefinitely. TIMEOUT_CYC is ignored.

Test Plan:
- Reset, port_cfg=0x8000_1F90, 100 consecutive photons 0..99, out_ready=1 → header 0xF0E1_1F90_0000_0064 at cycle N+2 with sop. Then 100 body words 0..99, eop on word 99; seq of the next header = 1.
- 5 photons only, TIMEOUT_CYC=16, macro defined → header nphot=5 after 16 idle cycles, eop on 5th word. Macro undefined → no output after 10000 cycles, fifo_count=5.
- out_ready toggled 1-0-0-1 during BODY → each word is held stable while stalled; no words are lost or duplicated; 100 words received in order.
- out_ready=0, 300 photons with FIFO_DEPTH=256 → fifo_count=256, drop_cnt=44. Simultaneous push+pop at full still drops the push.
- port_cfg[31] cleared during BODY → current packet completes with eop, FIFO then drains to 0, new photons ignored, drop_cnt unchanged.
- Assert user_rst_n=0 for one cycle mid-BODY → next cycle out_valid=0, fifo_count=0, seq=0; the next packet header has seq 0.
